// File: rtl/fifo_pair_reader_pkg.sv
// Shared types and constants for the dual-read FIFO consumer.
package fifo_pair_reader_pkg;

    // Value of rst that holds the block in reset.
    localparam logic RESET_STATE = 1'b0;

    localparam int DEF_WORD_L = 8;
    localparam int DEF_PORT_L = 8;

    // State encoding is {o_vld, h_vld}.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        HALF      = 2'b01,
        PAIR      = 2'b10,
        PAIR_HALF = 2'b11
    } pair_rd_state_t;

    // The pair register can take new data when it is empty or being drained.
    function automatic logic out_free(input pair_rd_state_t s, input logic pair_rdy);
        logic [1:0] bits;
        bits = s;
        return !bits[1] || pair_rdy;
    endfunction

endpackage

// File: rtl/fifo_pair_reader_if.sv
// FIFO dual-read port plus operand-pair stream toward the PE input stage.
interface fifo_pair_reader_if
    import fifo_pair_reader_pkg::*;
#(
    parameter int WORD_L = DEF_WORD_L,
    parameter int PORT_L = DEF_PORT_L
);
    localparam int W = WORD_L * PORT_L;

    logic [W-1:0] fifo_out_0;
    logic [W-1:0] fifo_out_1;
    logic         fifo_out_0_vld;
    logic         fifo_out_1_vld;
    logic         receiver_0_rdy;
    logic         receiver_1_rdy;
    logic         flush;
    logic [W-1:0] pair_a;
    logic [W-1:0] pair_b;
    logic         pair_vld;
    logic         pair_b_vld;
    logic         pair_rdy;

    // master is the reader; slave is the FIFO plus downstream consumer.
    modport master (
        input  fifo_out_0, fifo_out_1, fifo_out_0_vld, fifo_out_1_vld, flush, pair_rdy,
        output receiver_0_rdy, receiver_1_rdy, pair_a, pair_b, pair_vld, pair_b_vld
    );

    modport slave (
        output fifo_out_0, fifo_out_1, fifo_out_0_vld, fifo_out_1_vld, flush, pair_rdy,
        input  receiver_0_rdy, receiver_1_rdy, pair_a, pair_b, pair_vld, pair_b_vld
    );

endinterface

// File: rtl/fifo_pair_reader.sv
// Drains a 2-output FIFO into registered (a,b) operand pairs; an odd entry
// waits in a hold register for its partner or for flush.
module fifo_pair_reader
    import fifo_pair_reader_pkg::*;
#(
    parameter int WORD_L = DEF_WORD_L,
    parameter int PORT_L = DEF_PORT_L,
    parameter int CNT_L  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_pair_reader_if.master      bus,
    output logic                    idle,
    output logic [CNT_L-1:0]        pair_cnt
);
    localparam int W = WORD_L * PORT_L;

    pair_rd_state_t state, state_nx;
    logic [W-1:0]   hold;
    logic [W-1:0]   pair_a, pair_b;
    logic           pair_b_vld;
    logic           o_vld, h_vld, free;
    logic           r0, r1, pop0, pop1;
    logic           ld_ff, ld_hf, ld_hz, ld_hold;
    logic           o_nx, h_nx;

    // Pop decode: rdy depends only on state and pair_rdy; FIFO valids only gate the pops.
    always_comb begin
        logic [1:0] st;
        st       = state;
        o_vld    = st[1];
        h_vld    = st[0];
        free     = out_free(state, bus.pair_rdy);
        r0       = 1'b0;
        r1       = 1'b0;
        if (rst != RESET_STATE) begin
            r0 = free || !h_vld;
            r1 = free && !h_vld;
        end
        pop0     = r0 && bus.fifo_out_0_vld;
        pop1     = r1 && bus.fifo_out_1_vld;
        ld_ff    = 1'b0;
        ld_hf    = 1'b0;
        ld_hz    = 1'b0;
        ld_hold  = 1'b0;
        o_nx     = o_vld && !bus.pair_rdy;
        h_nx     = h_vld;
        if (free && !h_vld && pop0 && pop1) begin
            ld_ff = 1'b1;
            o_nx  = 1'b1;
        end else if (!h_vld && pop0) begin
            ld_hold = 1'b1;
            h_nx    = 1'b1;
        end else if (free && h_vld && pop0) begin
            ld_hf = 1'b1;
            o_nx  = 1'b1;
            h_nx  = 1'b0;
        end else if (free && h_vld && bus.flush) begin
            ld_hz = 1'b1;
            o_nx  = 1'b1;
            h_nx  = 1'b0;
        end
        state_nx = pair_rd_state_t'({o_nx, h_nx});
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) state <= EMPTY;
        else                    state <= state_nx;
    end

    // Hold register keeps the older, still unpaired entry.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) hold <= '0;
        else if (ld_hold)       hold <= bus.fifo_out_0;
    end

    // Pair register; b is cleared whenever it carries no data.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) begin
            pair_a     <= '0;
            pair_b     <= '0;
            pair_b_vld <= 1'b0;
        end else if (ld_ff) begin
            pair_a     <= bus.fifo_out_0;
            pair_b     <= bus.fifo_out_1;
            pair_b_vld <= 1'b1;
        end else if (ld_hf) begin
            pair_a     <= hold;
            pair_b     <= bus.fifo_out_0;
            pair_b_vld <= 1'b1;
        end else if (ld_hz) begin
            pair_a     <= hold;
            pair_b     <= '0;
            pair_b_vld <= 1'b0;
        end else if (o_vld && bus.pair_rdy) begin
            pair_b     <= '0;
            pair_b_vld <= 1'b0;
        end
    end

    // Accepted-pair counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE)         pair_cnt <= '0;
        else if (o_vld && bus.pair_rdy) pair_cnt <= pair_cnt + CNT_L'(1);
    end

    assign bus.receiver_0_rdy = r0;
    assign bus.receiver_1_rdy = r1;
    assign bus.pair_a         = pair_a;
    assign bus.pair_b         = pair_b;
    assign bus.pair_vld       = o_vld;
    assign bus.pair_b_vld     = pair_b_vld;
    assign idle               = (state == EMPTY);

    a_r1_needs_r0: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
        bus.receiver_1_rdy |-> bus.receiver_0_rdy);
    a_pop1_needs_pop0: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
        pop1 |-> pop0);
    a_hold_stable: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
        (o_vld && !bus.pair_rdy) |=> (o_vld && $stable(pair_a) && $stable(pair_b) && $stable(pair_b_vld)));

endmodule

// File: tb/tb_fifo_pair_reader.sv
// Directed bench for fifo_pair_reader with a queue-backed FIFO on the read side.
module tb_fifo_pair_reader;
    localparam int WORD_L = 8;
    localparam int PORT_L = 8;
    localparam int CNT_L  = 4;
    localparam int W      = WORD_L * PORT_L;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             idle;
    logic [CNT_L-1:0] pair_cnt;
    logic [W-1:0]     q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    fifo_pair_reader_if #(.WORD_L(WORD_L), .PORT_L(PORT_L)) bus();

    fifo_pair_reader #(.WORD_L(WORD_L), .PORT_L(PORT_L), .CNT_L(CNT_L)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .idle     (idle),
        .pair_cnt (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b}};
    endfunction

    task automatic refresh();
        bus.fifo_out_0_vld = (q.size() >= 1);
        bus.fifo_out_1_vld = (q.size() >= 2);
        bus.fifo_out_0     = (q.size() >= 1) ? q[0] : '0;
        bus.fifo_out_1     = (q.size() >= 2) ? q[1] : '0;
    endtask

    task automatic push(input logic [W-1:0] d);
        q.push_back(d);
        refresh();
    endtask

    // One clock: sample pops before the edge, retire them just after it.
    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = bus.receiver_0_rdy & bus.fifo_out_0_vld;
        p1 = bus.receiver_1_rdy & bus.fifo_out_1_vld;
        @(posedge clk);
        #1;
        if (p0) void'(q.pop_front());
        if (p1) void'(q.pop_front());
        refresh();
    endtask

    initial begin
        bus.flush    = 1'b0;
        bus.pair_rdy = 1'b0;
        refresh();

        // Reset state
        #2;
        check("rst_vld",  {bus.pair_vld, bus.pair_b_vld}, 0);
        check("rst_rdy",  {bus.receiver_0_rdy, bus.receiver_1_rdy}, 0);
        check("rst_idle", idle, 1);
        check("rst_cnt",  pair_cnt, 0);
        check("rst_ab",   {bus.pair_a, bus.pair_b}, 0);
        tick();
        rst = 1'b1;
        bus.pair_rdy = 1'b1;

        // Burst A,B,C,D
        push(ent(8'hA1)); push(ent(8'hB2)); push(ent(8'hC3)); push(ent(8'hD4));
        tick();
        check("burst_ab", {bus.pair_a, bus.pair_b}, {ent(8'hA1), ent(8'hB2)});
        check("burst_v1", {bus.pair_vld, bus.pair_b_vld}, 2'b11);
        tick();
        check("burst_cd", {bus.pair_a, bus.pair_b}, {ent(8'hC3), ent(8'hD4)});
        check("burst_cnt1", pair_cnt, 1);
        tick();
        check("burst_cnt2", pair_cnt, 2);
        check("burst_idle", idle, 1);
        check("burst_vld0", bus.pair_vld, 0);

        // Odd trickle: A, then B three cycles later
        push(ent(8'h11));
        tick();
        check("odd_half", {idle, bus.pair_vld, bus.receiver_0_rdy, bus.receiver_1_rdy}, 4'b0010);
        tick();
        check("odd_r1_a", {idle, bus.receiver_1_rdy}, 2'b00);
        tick();
        check("odd_r1_b", {idle, bus.receiver_1_rdy}, 2'b00);
        push(ent(8'h22));
        tick();
        check("odd_ab", {bus.pair_a, bus.pair_b}, {ent(8'h11), ent(8'h22)});
        check("odd_bv", {bus.pair_vld, bus.pair_b_vld}, 2'b11);
        tick();
        check("odd_cnt", {idle, pair_cnt}, {1'b1, 4'd3});

        // Backpressure: E,F,G with pair_rdy low for 5 cycles
        bus.pair_rdy = 1'b0;
        push(ent(8'hE5)); push(ent(8'hF6)); push(ent(8'h67));
        tick();
        check("bp_ef", {bus.pair_a, bus.pair_b}, {ent(8'hE5), ent(8'hF6)});
        tick();
        check("bp_hold_rdy", {bus.receiver_0_rdy, bus.receiver_1_rdy}, 0);
        push(ent(8'h78));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stable", {bus.pair_a, bus.pair_b}, {ent(8'hE5), ent(8'hF6)});
            check("bp_rdy", {bus.pair_vld, bus.receiver_0_rdy, bus.receiver_1_rdy}, 3'b100);
        end
        check("bp_cnt", pair_cnt, 3);
        bus.pair_rdy = 1'b1;
        tick();
        check("bp_gk", {bus.pair_a, bus.pair_b}, {ent(8'h67), ent(8'h78)});
        check("bp_cnt4", pair_cnt, 4);
        tick();
        check("bp_drain", {idle, pair_cnt}, {1'b1, 4'd5});

        // Flush with empty FIFO releases a half pair
        push(ent(8'h99));
        tick();
        bus.flush = 1'b1;
        tick();
        check("fl_half", {bus.pair_a, bus.pair_b}, {ent(8'h99), {W{1'b0}}});
        check("fl_bv", {bus.pair_vld, bus.pair_b_vld}, 2'b10);
        bus.flush = 1'b0;
        tick();
        check("fl_idle", {idle, pair_cnt}, {1'b1, 4'd6});

        // Flush loses to pairing with a fresh entry
        push(ent(8'h5A));
        tick();
        push(ent(8'h5B));
        bus.flush = 1'b1;
        tick();
        check("fl_pair", {bus.pair_a, bus.pair_b}, {ent(8'h5A), ent(8'h5B)});
        check("fl_pair_bv", {bus.pair_vld, bus.pair_b_vld}, 2'b11);
        bus.flush = 1'b0;
        tick();
        check("fl_pair_cnt", {idle, pair_cnt}, {1'b1, 4'd7});

        // Flush with nothing held does nothing
        bus.flush = 1'b1;
        tick();
        check("fl_noop", {idle, bus.pair_vld, pair_cnt}, {2'b10, 4'd7});
        bus.flush = 1'b0;

        // Reset mid-operation with a pair and a held entry present
        bus.pair_rdy = 1'b0;
        push(ent(8'h31)); push(ent(8'h32)); push(ent(8'h33));
        tick();
        tick();
        check("mr_pre", idle, 0);
        push(ent(8'h34));
        rst = 1'b0;
        #1;
        check("mr_vld",  {bus.pair_vld, bus.pair_b_vld, idle}, 3'b001);
        check("mr_ab",   {bus.pair_a, bus.pair_b}, 0);
        check("mr_rdy",  {bus.receiver_0_rdy, bus.receiver_1_rdy}, 0);
        check("mr_cnt",  pair_cnt, 0);
        tick();
        tick();
        rst = 1'b1;
        bus.pair_rdy = 1'b1;
        #1;
        check("mr_post", {idle, pair_cnt}, {1'b1, 4'd0});
        check("mr_fifo", q.size(), 1);
        push(ent(8'h35));
        tick();
        check("mr_st", {bus.pair_a, bus.pair_b}, {ent(8'h34), ent(8'h35)});
        tick();
        check("mr_cnt1", pair_cnt, 1);

        // Back-to-back pairs and counter wrap: 17 accepted pairs total
        for (int i = 0; i < 32; i++) push(ent(64 + i));
        for (int k = 0; k < 16; k++) begin
            tick();
            check("b2b", {bus.pair_a, bus.pair_b}, {ent(64 + 2*k), ent(65 + 2*k)});
        end
        tick();
        check("wrap_cnt", {idle, pair_cnt}, {1'b1, 4'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
